// File: rtl/fns_pkg.sv
// fns_pkg: shared types, defaults and Fibonacci weight function for the FTF receive path
package fns_pkg;
  localparam int NBIT_DEF = 23;
  localparam int FBLEN23 = 17;
  localparam int unsigned FIB_LIMIT = 75025;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;
  // W[k] = F(k+2): 1, 2, 3, 5, ...
  function automatic int unsigned fib_w(input int k);
    int unsigned a, b, t;
    a = 1;
    b = 2;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction
endpackage

// File: rtl/fns_rx_dec_23_ftf_check.sv
// ftf_check: flags a codeword whose odd bits are set without the required even neighbours
// Ports: code (N-bit codeword in), bad (1 when any adjacent pair breaks the rule)
module ftf_check #(
  parameter int N = 23
) (
  input  logic [N-1:0] code,
  output logic         bad
);
  always_comb begin
    bad = 1'b0;
    for (int j = 0; j <= N - 3; j++)
      bad = bad | ((j % 2 == 1) ? (code[j] & ~code[j+1]) : (~code[j] & code[j+1]));
  end
endmodule

// File: rtl/fns_rx_dec_23.sv
// fns_rx_dec_23: serial Fibonacci-weighted decoder for FTF TSV codewords with error counting
// Ports: clock/reset; tsv_in/in_valid/in_ready capture side; data_out/ftf_err/out_valid/out_ready result side; err_count saturating error tally
module fns_rx_dec_23
  import fns_pkg::*;
#(
  parameter int NBIT = NBIT_DEF,
  parameter int DLEN = FBLEN23
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NBIT-1:0] tsv_in,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [DLEN-1:0] data_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            ftf_err,
  output logic [15:0]     err_count
);
  localparam int KW = $clog2(NBIT);
  state_t          state;
  logic [NBIT-1:0] code;
  logic [KW-1:0]   k;
  logic [DLEN-1:0] acc, acc_next;
  logic [DLEN-1:0] w [NBIT];
  logic            fin, rule_bad;
  for (genvar i = 0; i < NBIT; i++) begin : g_w
    assign w[i] = DLEN'(fib_w(i));
  end
  ftf_check #(.N(NBIT)) u_chk (.code(code), .bad(rule_bad));
  assign acc_next  = acc + (code[k] ? w[k] : '0);
  assign in_ready  = state == IDLE;
  assign out_valid = state == HOLD;
  assign data_out  = acc;
  // fin spends one extra ACCUM cycle after bit 0 so the verdict is latched from the final sum
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      code      <= '0;
      k         <= KW'(NBIT - 1);
      acc       <= '0;
      fin       <= 1'b0;
      ftf_err   <= 1'b0;
      err_count <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          code  <= tsv_in;
          acc   <= '0;
          k     <= KW'(NBIT - 1);
          fin   <= 1'b0;
          state <= ACCUM;
        end
        ACCUM: if (fin) begin
          fin     <= 1'b0;
          ftf_err <= rule_bad | (32'(acc) >= FIB_LIMIT);
          state   <= HOLD;
        end else begin
          acc <= acc_next;
          fin <= k == '0;
          k   <= (k == '0) ? k : k - KW'(1);
        end
        HOLD: if (out_ready) begin
          state <= IDLE;
          if (ftf_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fns_rx_dec_23.sv
// tb_fns_rx_dec_23: scoreboard bench for the FTF decoder
module tb_fns_rx_dec_23;
  logic        clock = 1'b0;
  logic        reset;
  logic [22:0] tsv_in;
  logic        in_valid, in_ready, out_valid, out_ready, ftf_err;
  logic [16:0] data_out;
  logic [15:0] err_count;
  typedef struct {
    int unsigned data;
    bit          err;
  } exp_t;
  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned exp_cnt = 0;
  always #5 clock = ~clock;
  fns_rx_dec_23 dut (
    .clock(clock), .reset(reset), .tsv_in(tsv_in), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready), .ftf_err(ftf_err),
    .err_count(err_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  function automatic int unsigned model_sum(input logic [22:0] c);
    int unsigned a, b, t, s;
    a = 1;
    b = 2;
    s = 0;
    for (int i = 0; i < 23; i++) begin
      if (c[i]) s += a;
      t = a + b;
      a = b;
      b = t;
    end
    return s & 32'h1FFFF;
  endfunction
  function automatic bit model_err(input logic [22:0] c);
    bit e;
    e = model_sum(c) >= 75025;
    for (int j = 0; j <= 20; j++) begin
      if (j % 2 == 1 && c[j] && !c[j+1]) e = 1;
      if (j % 2 == 0 && !c[j] && c[j+1]) e = 1;
    end
    return e;
  endfunction
  // drop any odd bit whose even neighbours are not both set
  function automatic logic [22:0] legalize(input logic [22:0] c);
    logic [22:0] r;
    r = c;
    for (int j = 1; j < 23; j += 2)
      if (r[j] && (!r[j-1] || (j <= 20 && !r[j+1]))) r[j] = 1'b0;
    return r;
  endfunction
  task automatic run(input logic [22:0] c, input int hold);
    exp_t e;
    int   lat;
    e.data = model_sum(c);
    e.err  = model_err(c);
    sb.push_back(e);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    tsv_in   = c;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(negedge clock);
      lat++;
    end
    chk("latency", lat, 24);
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk("data_out", data_out, e.data);
    chk("ftf_err", ftf_err, e.err);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      tsv_in   = ~c;
      @(negedge clock);
      chk("hold_data", data_out, e.data);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    if (e.err && exp_cnt != 16'hFFFF) exp_cnt++;
    chk("valid_drop", out_valid, 0);
    chk("no_capture", data_out, e.data);
    chk("err_count", err_count, exp_cnt);
  endtask
  initial begin
    int seen;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tsv_in    = '0;
    repeat (3) @(negedge clock);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_err", ftf_err, 0);
    chk("rst_cnt", err_count, 0);
    reset = 1'b0;
    @(negedge clock);
    run(23'd0, 0);
    run(23'b10, 0);
    run(23'h7FFFFF, 0);
    run(23'h400000, 0);
    run(23'h3FFFFF, 0);
    for (int i = 0; i < 120; i++)
      run(legalize(23'($urandom) | 23'($urandom)), 0);
    for (int i = 0; i < 10; i++)
      run(23'($urandom), 0);
    run(legalize(23'h2A5F3C), 10);
    in_valid = 1'b1;
    tsv_in   = 23'h00000F;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ready", in_ready, 1);
    chk("midrst_data", data_out, 0);
    chk("midrst_cnt", err_count, 0);
    exp_cnt = 0;
    reset = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clock);
      if (out_valid) seen = 1;
    end
    chk("midrst_discard", seen, 0);
    run(23'h00001D, 0);
    force dut.err_count = 16'hFFFE;
    @(negedge clock);
    release dut.err_count;
    @(negedge clock);
    exp_cnt = 16'hFFFE;
    chk("preload", err_count, 16'hFFFE);
    run(23'b10, 0);
    run(23'b10, 0);
    run(23'h7FFFFF, 0);
    chk("sat_final", err_count, 16'hFFFF);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fns_rx_dec_23.md
FNS_RX_DEC_23 -- requirements
Module: fns_rx_dec_23

Interface
REQ-001 Parameter: NBIT, default 23, number of TSV lines (codeword bits).
REQ-002 Parameter: DLEN, default `FBLEN23 (17), decoded data width.
REQ-003 clock  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 tsv_in  input  NBIT  received FTF codeword from the TSV bundle.
REQ-006 in_valid  input  1  tsv_in holds a codeword.
REQ-007 in_ready  output  1  block can accept a codeword.
REQ-008 data_out  output  DLEN  decoded binary value.
REQ-009 out_valid  output  1  data_out and ftf_err are valid.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 ftf_err  output  1  captured codeword violated the FTF rule or decoded to 75025 or more.
REQ-012 err_count  output  16  saturating count of results delivered with ftf_err=1.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, ACCUM and HOLD.
REQ-014 In IDLE, in_ready SHALL be 1; in all other states it SHALL be 0.
REQ-015 A handshake (in_valid & in_ready) SHALL register tsv_in into an internal code register, clear the accumulator, set bit index k=NBIT-1 and move the FSM to ACCUM.
REQ-016 In ACCUM, each cycle SHALL add W[k] to the accumulator when code[k]=1, then decrement k; after k=0 is processed, the FSM SHALL go to HOLD.
REQ-017 Weights SHALL be W[k]=F(k+2) with F(1)=F(2)=1, so W[0]=1, W[1]=2, W[2]=3 and W[22]=46368.
REQ-018 The accumulator SHALL be DLEN bits wide and SHALL NOT overflow for any legal codeword.
REQ-019 Latency: after a handshake at edge 0, out_valid SHALL rise after edge NBIT+1 (edge 24 for the default).
REQ-020 FTF check SHALL run combinationally on the captured code and be latched by the time the FSM enters HOLD.
  - Violation: any odd j in 0..NBIT-3 with code[j]=1 and code[j+1]=0.
  - Violation: any even j in 0..NBIT-3 with code[j]=0 and code[j+1]=1.
  - Violation: final sum of 75025 or more.
REQ-021 In HOLD, out_valid=1, and data_out and ftf_err SHALL stay stable until out_ready=1.
REQ-022 On out_ready=1 in HOLD, the FSM SHALL return to IDLE and out_valid SHALL drop on the next cycle.
REQ-023 out_ready SHALL have no effect outside HOLD.
REQ-024 in_valid SHALL be ignored outside IDLE; no codeword is queued.
REQ-025 err_count SHALL increment on a HOLD-exit handshake with ftf_err=1 and SHALL saturate at 16'hFFFF.
REQ-026 An illegal codeword SHALL still decode to its raw weighted sum, truncated to DLEN bits.

Reset
REQ-027 While reset=1, the block SHALL hold:
  - FSM=IDLE, k=NBIT-1.
  - Accumulator, code register, data_out, ftf_err and err_count at 0.
  - out_valid=0, in_ready=1.
REQ-028 Reset asserted mid-ACCUM or in HOLD SHALL discard the transaction immediately; no output SHALL appear after release.

Structure
REQ-029 A shared package fns_pkg SHALL hold:
  - the FSM state enum;
  - NBIT/DLEN defaults;
  - the constant 75025;
  - a constant function returning W[k].
REQ-030 The FTF rule check SHALL be a separate combinational sub-module, ftf_check, reused by the encoder benches.
REQ-031 The remaining datapath (counter, accumulator, FSM) SHALL stay in fns_rx_dec_23.

Verification
REQ-032 The bench SHALL cover at least these scenarios:
  - Encode 0 through the 23-bit FTF encoder, feed the result -> data_out=0, ftf_err=0, out_valid on edge 24.
  - Random 100000 values in 0..75024 through the encoder, out_ready=1 -> data_out equals input every time, err_count=0.
  - tsv_in=23'b...0010 (bit1=1, bit2=0, odd j=1) -> ftf_err=1, data_out=2, err_count increments.
  - Hold out_ready=0 for 10 cycles in HOLD while pulsing in_valid -> data_out stable, in_ready=0, no new capture.
  - Assert reset at ACCUM cycle 10 -> out_valid stays 0, next codeword decodes correctly.
  - Preload 65535 errors, inject one more -> err_count stays 16'hFFFF.
